// File: rtl/serial_out_scheduler.sv
// Command scheduler for a bank of serial_out channels: queues decoded commands and sequences
// start/stop ticks onto the addressed channel while tracking per-channel busy state.
module serial_out_scheduler #(
    parameter int unsigned DATA_BIT   = 32,
    parameter int unsigned CH_NUM     = 4,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_cmd_valid,
    input  logic [DATA_BIT-1:0] i_output_pattern,
    input  logic [DATA_BIT-1:0] i_freq_pattern,
    input  logic [3:0]          i_sel_out,
    input  logic                i_start,
    input  logic                i_stop,
    input  logic                i_mode,
    input  logic [CH_NUM-1:0]   i_ch_done_tick,
    output logic [CH_NUM-1:0]   o_ch_start,
    output logic [CH_NUM-1:0]   o_ch_stop,
    output logic [CH_NUM-1:0]   o_ch_mode,
    output logic [DATA_BIT-1:0] o_output_pattern,
    output logic [DATA_BIT-1:0] o_freq_pattern,
    output logic [CH_NUM-1:0]   o_ch_busy,
    output logic                o_cmd_full,
    output logic                o_cmd_drop_tick,
    output logic                o_update_done_tick
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic [DATA_BIT-1:0] op;
        logic [DATA_BIT-1:0] fp;
        logic [3:0]          sel;
        logic                start;
        logic                stop;
        logic                mode;
    } cmd_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_PREEMPT,
        S_WAIT,
        S_ISSUE,
        S_DONE
    } state_t;

    cmd_t                r_mem [FIFO_DEPTH];
    logic [AW-1:0]       r_wr_ptr;
    logic [AW-1:0]       r_rd_ptr;
    logic [AW:0]         r_count;
    logic                r_full_drop;
    cmd_t                r_head;
    state_t              r_state;
    logic [CH_NUM-1:0]   r_busy;
    logic [CH_NUM-1:0]   r_chmode;

    cmd_t                w_in;
    logic                w_full;
    logic                w_empty;
    logic                w_push;
    logic                w_pop;
    state_t              w_state_next;
    logic [CH_NUM-1:0]   w_sel_oh;
    logic                w_sel_bad;
    logic                w_sel_busy;
    logic                w_sel_rpt;
    logic                w_clr_sel;
    logic                w_set_sel;
    logic                w_sel_drop;
    logic [CH_NUM-1:0]   w_busy_next;
    logic [CH_NUM-1:0]   w_chmode_next;

    assign w_in    = '{op: i_output_pattern, fp: i_freq_pattern, sel: i_sel_out,
                       start: i_start, stop: i_stop, mode: i_mode};
    assign w_full  = (r_count == (AW+1)'(FIFO_DEPTH));
    assign w_empty = (r_count == '0);
    // A command arriving while full is lost even if the FSM pops in the same cycle.
    assign w_push  = i_cmd_valid && !w_full;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_full_drop <= 1'b0;
            r_head      <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_head   <= r_mem[r_rd_ptr];
            end
            r_count     <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
            r_full_drop <= i_cmd_valid && w_full;
        end
    end

    always_comb begin
        w_sel_oh = '0;
        for (int unsigned i = 0; i < CH_NUM; i++) begin
            if (r_head.sel == 4'(i)) begin
                w_sel_oh[i] = 1'b1;
            end
        end
    end

    assign w_sel_bad  = ~|w_sel_oh;
    assign w_sel_busy = |(r_busy & w_sel_oh);
    assign w_sel_rpt  = |(r_chmode & w_sel_oh);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next       = r_state;
        w_pop              = 1'b0;
        w_clr_sel          = 1'b0;
        w_set_sel          = 1'b0;
        w_sel_drop         = 1'b0;
        o_ch_start         = '0;
        o_ch_stop          = '0;
        o_ch_mode          = '0;
        o_output_pattern   = '0;
        o_freq_pattern     = '0;
        o_update_done_tick = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_state_next = S_CHECK;
                end
            end
            S_CHECK: begin
                if (w_sel_bad) begin
                    w_sel_drop   = 1'b1;
                    w_state_next = S_DONE;
                end else if (r_head.stop) begin
                    o_ch_stop    = w_sel_oh;
                    w_clr_sel    = 1'b1;
                    w_state_next = S_DONE;
                end else if (r_head.start) begin
                    if (w_sel_busy) begin
                        w_state_next = w_sel_rpt ? S_PREEMPT : S_WAIT;
                    end else begin
                        w_state_next = S_ISSUE;
                    end
                end else begin
                    w_state_next = S_DONE;
                end
            end
            S_PREEMPT: begin
                o_ch_stop    = w_sel_oh;
                w_state_next = S_ISSUE;
            end
            S_WAIT: begin
                if (!w_sel_busy) begin
                    w_state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                o_ch_start       = w_sel_oh;
                o_ch_mode        = w_sel_oh & {CH_NUM{r_head.mode}};
                o_output_pattern = r_head.op;
                o_freq_pattern   = r_head.fp;
                w_set_sel        = 1'b1;
                w_state_next     = S_DONE;
            end
            S_DONE: begin
                o_update_done_tick = 1'b1;
                w_state_next       = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Done ticks only retire one-shot channels; a set in the same cycle overrides any clear.
    always_comb begin
        w_busy_next   = r_busy & ~(i_ch_done_tick & ~r_chmode);
        w_chmode_next = r_chmode;
        if (w_clr_sel) begin
            w_busy_next = w_busy_next & ~w_sel_oh;
        end
        if (w_set_sel) begin
            w_busy_next   = w_busy_next | w_sel_oh;
            w_chmode_next = (r_chmode & ~w_sel_oh) | (w_sel_oh & {CH_NUM{r_head.mode}});
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy   <= '0;
            r_chmode <= '0;
        end else begin
            r_busy   <= w_busy_next;
            r_chmode <= w_chmode_next;
        end
    end

    assign o_ch_busy       = r_busy;
    assign o_cmd_full      = w_full;
    assign o_cmd_drop_tick = r_full_drop | w_sel_drop;

endmodule

// File: doc/serial_out_scheduler.md
# serial_out_scheduler

Command scheduler that sits between the frame decoder and a bank of `CH_NUM` serial_out channels. It queues decoded commands in a small FIFO and sequences start and stop ticks onto the addressed channel, tracking per-channel busy state. It holds a start to a running one-shot channel until that channel finishes, and preempts a running repeat channel. Pattern data is placed on a shared bus that the addressed channel samples on its start tick.

## Interface
- `DATA_BIT`, 32, width of output and frequency patterns
- `CH_NUM`, 4, number of serial_out channels (1–16)
- `FIFO_DEPTH`, 4, command FIFO entries (power of two, ≥2)

Ports:
- `clk` input 1: single clock; all logic on rising edge
- `rst` input 1: synchronous, active-high reset
- `i_cmd_valid` input 1: one-cycle decoder done tick; command fields valid this cycle
- `i_output_pattern` input DATA_BIT: output pattern field
- `i_freq_pattern` input DATA_BIT: frequency pattern field
- `i_sel_out` input 4: target channel index
- `i_start` input 1: start request
- `i_stop` input 1: stop request
- `i_mode` input 1: channel mode, 0 = one-shot, 1 = repeat
- `i_ch_done_tick` input CH_NUM: per-channel done tick from serial_out
- `o_ch_start` output CH_NUM: one-cycle start tick to the addressed channel
- `o_ch_stop` output CH_NUM: one-cycle stop tick to the addressed channel
- `o_ch_mode` output CH_NUM: mode bit, valid with start tick
- `o_output_pattern` output DATA_BIT: shared pattern bus; 0 when not issuing a start
- `o_freq_pattern` output DATA_BIT: shared frequency bus; 0 when not issuing a start
- `o_ch_busy` output CH_NUM: per-channel busy flags
- `o_cmd_full` output 1: FIFO holds FIFO_DEPTH entries
- `o_cmd_drop_tick` output 1: command lost, either because the FIFO was full or the select was invalid
- `o_update_done_tick` output 1: one-cycle pulse per retired command

## Operation
- FIFO entry = {output_pattern, freq_pattern, sel_out, start, stop, mode}.
- Push on `i_cmd_valid` when not full.
- `i_cmd_valid` while full: command discarded and `o_cmd_drop_tick` pulses next cycle. This holds even if a pop occurs in the same cycle.
- FSM states:
  - S_IDLE: if the FIFO is non-empty, pop the head into the head registers and go to S_CHECK.
  - S_CHECK, in priority order:
    1. `sel_out ≥ CH_NUM`: pulse `o_cmd_drop_tick`, go to S_DONE.
    2. stop=1 (including stop=1 with start=1): `o_ch_stop[sel]`=1, clear busy[sel], go to S_DONE.
    3. start=1 and busy[sel] and chmode[sel]=1 (repeat): go to S_PREEMPT.
    4. start=1 and busy[sel] and chmode[sel]=0: go to S_WAIT.
    5. start=1 and not busy: go to S_ISSUE.
    6. start=0 and stop=0: no-op, go to S_DONE.
  - S_PREEMPT: `o_ch_stop[sel]`=1 for one cycle, go to S_ISSUE.
  - S_WAIT: stay until busy[sel] clears, then go to S_ISSUE.
  - S_ISSUE:
    - `o_ch_start[sel]`=1 and `o_ch_mode[sel]`=mode.
    - Pattern buses driven from the head registers.
    - Set busy[sel], store chmode[sel]=mode, go to S_DONE.
  - S_DONE: `o_update_done_tick`=1, go to S_IDLE.
- Busy tracking:
  - busy[ch] clears on `i_ch_done_tick[ch]` only when chmode[ch]=0.
  - Done ticks for repeat or idle channels are ignored.
  - Set and clear in the same cycle on the same channel: set wins.
- The FIFO continues accepting commands while the FSM is in S_WAIT (head-of-line blocking is intended).
- Only one-hot bits of `o_ch_start` and `o_ch_stop` are ever asserted. They are never both asserted in the same cycle.

## Timing
- Reset (rst=1 at a clock edge) returns the block to its idle condition:
  - FSM to S_IDLE; FIFO emptied.
  - All busy and chmode bits = 0.
  - All outputs = 0.
  - An in-flight command is abandoned with no tick issued.
- All outputs are decoded from registers; there is no combinational input-to-output path.
- Latency, empty FIFO, idle channel, `i_cmd_valid` at cycle t:
  - Entry written at the t+1 edge; pop in cycle t+1.
  - S_CHECK in t+2, S_ISSUE in t+3 (start tick), S_DONE in t+4 (`o_update_done_tick`), S_IDLE in t+5.
- Stop path: stop tick in t+2 and done tick in t+3.
- Preempt path: stop tick in t+3, start tick in t+4.
- Wait path: `i_ch_done_tick` at cycle d; start tick at d+2.
- `o_cmd_full` updates the cycle after a push or pop.
- Back-to-back `i_cmd_valid` pulses each take one FIFO slot.

## Test plan
- Reset, then a start command (sel=1, mode=0, pattern 0xA5A5_0F0F) at t: `o_ch_start`=4'b0010 at t+3 with the bus = 0xA5A5_0F0F; `o_ch_busy[1]`=1; `o_update_done_tick` at t+4.
- Channel 2 busy in one-shot, start to ch2 queued: no start until `i_ch_done_tick[2]` at d, then start tick at d+2; other commands queued behind it stay pending.
- Channel 0 busy in repeat, new start to ch0: `o_ch_stop`=4'b0001 exactly one cycle before `o_ch_start`=4'b0001; busy stays 1.
- Command with start=1 and stop=1 for ch3: only `o_ch_stop[3]` pulses; busy[3]=0. Command with sel=7 (CH_NUM=4): `o_cmd_drop_tick` and no channel tick.
- Five back-to-back commands while the FSM is blocked in S_WAIT, FIFO_DEPTH=4: `o_cmd_full`=1 after the fourth; the fifth raises `o_cmd_drop_tick`; the four queued commands later issue in order.
- Assert rst during S_WAIT with 3 entries queued: next cycle all outputs = 0, FIFO empty, busy = 0, and no tick fires afterwards.
